// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite initiator.
package axil_pkg;

    localparam int AXIL_AW = 28;
    localparam int AXIL_DW = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP,
        RSP
    } state_t;

    // OKAY and EXOKAY are success; SLVERR and DECERR are reported as errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator bridging a valid/ready MMIO request port.
// Optional response-wait timeout and stale-beat draining: define AXIL_TIMEOUT_EN.
module axil_master
    import axil_pkg::*;
#(
    parameter int AW      = AXIL_AW,
    parameter int DW      = AXIL_DW,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_wstrb,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,

    output logic [AW-1:0]   m_axi_awaddr,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    output logic [AW-1:0]   m_axi_araddr,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [DW-1:0]   m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready
);

    state_t            r_state;
    logic              r_req_ready;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_wstrb;
    logic              r_arvalid;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_rready;
    logic              r_bready;
    logic              r_rsp_valid;
    logic [DW-1:0]     r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_aw_fire;
    logic              w_w_fire;
    logic              w_to_hit;

`ifdef AXIL_TIMEOUT_EN
    // R/B ready idle high so stray beats are swallowed rather than left pending.
    localparam logic        DRAIN   = 1'b1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 2);

    logic [15:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == RDATA || r_state == WRESP) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_to_hit = (r_to_cnt == TO_LAST);
`else
    localparam logic DRAIN = 1'b0;
    localparam int   unused_timeout = TIMEOUT;

    assign w_to_hit = 1'b0;
`endif

    assign w_aw_fire = r_awvalid && m_axi_awready;
    assign w_w_fire  = r_wvalid  && m_axi_wready;

    // NOTE: state and outputs update with <= only, so every branch below reads pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_arvalid   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rready    <= DRAIN;
            r_bready    <= DRAIN;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        r_rready    <= 1'b0;
                        r_bready    <= 1'b0;
                        if (req_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WREQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_bready  <= DRAIN;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_err   <= resp_is_err(m_axi_rresp);
                        r_rsp_valid <= 1'b1;
                        r_rready    <= DRAIN;
                        r_state     <= RSP;
                    end else if (w_to_hit) begin
                        r_rsp_rdata <= DW'(32'hdead_beef);
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rready    <= DRAIN;
                        r_state     <= RSP;
                    end
                end
                WREQ: begin
                    // Each valid stays up until its own ready; the channels finish in either order.
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_rready  <= DRAIN;
                        r_state   <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= resp_is_err(m_axi_bresp);
                        r_rsp_valid <= 1'b1;
                        r_bready    <= DRAIN;
                        r_state     <= RSP;
                    end else if (w_to_hit) begin
                        r_rsp_rdata <= DW'(32'hdead_beef);
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_bready    <= DRAIN;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: behavioural AXI-Lite slave plus response scoreboard.
// Build with AXIL_TIMEOUT_EN defined to also exercise the response timeout.
`timescale 1ns/1ps
module tb_axil_master;
    import axil_pkg::*;

    localparam int AW      = 28;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 16;
`ifdef AXIL_TIMEOUT_EN
    localparam logic TB_DRAIN = 1'b1;
`else
    localparam logic TB_DRAIN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;

    always #5 clk = ~clk;

    axil_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Scoreboard: expectations pushed at request time, observations logged by the monitor.
    rsp_t sb[$];
    rsp_t obs[64];
    int   obs_wr = 0;
    int   obs_rd = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Slave knobs, set by the tests.
    int            ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic          r_enable = 1'b1, b_enable = 1'b1, rd_from_addr = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    logic [1:0]    slv_rresp = 2'b00, slv_bresp = 2'b00;

    // Slave state, owned by the slave process.
    logic          r_pending = 1'b0, b_pending = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic          s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;
    logic [AW-1:0] s_araddr;
    logic [DW-1:0] r_lat_data = '0;
    int            ar_wc = 0, aw_wc = 0, w_wc = 0;

    always begin
        @(posedge clk);
        s_ar_hs  = m_axi_arvalid && m_axi_arready;
        s_r_hs   = m_axi_rvalid && m_axi_rready;
        s_aw_hs  = m_axi_awvalid && m_axi_awready;
        s_w_hs   = m_axi_wvalid && m_axi_wready;
        s_b_hs   = m_axi_bvalid && m_axi_bready;
        s_araddr = m_axi_araddr;
        #1;
        if (rst) begin
            r_pending = 1'b0; b_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        end else begin
            if (s_r_hs) r_pending = 1'b0;
            if (s_ar_hs) begin
                r_pending  = 1'b1;
                r_lat_data = rd_from_addr ? {4'hA, s_araddr} : slv_rdata;
            end
            if (s_b_hs) b_pending = 1'b0;
            if (s_aw_hs) aw_got = 1'b1;
            if (s_w_hs) w_got = 1'b1;
            if (aw_got && w_got) begin
                b_pending = 1'b1; aw_got = 1'b0; w_got = 1'b0;
            end
        end
        m_axi_rvalid = r_pending && r_enable;
        m_axi_rdata  = r_lat_data;
        m_axi_rresp  = slv_rresp;
        m_axi_bvalid = b_pending && b_enable;
        m_axi_bresp  = slv_bresp;
        if (m_axi_arvalid) begin m_axi_arready = (ar_wc >= ar_wait); ar_wc++; end
        else begin m_axi_arready = 1'b0; ar_wc = 0; end
        if (m_axi_awvalid) begin m_axi_awready = (aw_wc >= aw_wait); aw_wc++; end
        else begin m_axi_awready = 1'b0; aw_wc = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_wc >= w_wait); w_wc++; end
        else begin m_axi_wready = 1'b0; w_wc = 0; end
    end

    // Monitor: handshake counters, timestamps and response log.
    int            cyc = 0, hs_cyc = 0, ar_hs_cyc = 0, rsp_first_cyc = 0, rsp_hs_cyc = 0;
    int            n_ar = 0, n_b = 0, n_r = 0, awv_cycles = 0, wv_cycles = 0;
    logic          rsp_prev = 1'b0, aw_hold = 1'b0, aw_unstable = 1'b0;
    logic [AW-1:0] aw_hold_addr = '0, aw_hs_addr = '0;
    logic [DW-1:0] w_hs_data = '0;
    logic [SW-1:0] w_hs_strb = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rsp_prev = 1'b0;
            aw_hold  = 1'b0;
        end else begin
            if (req_valid && req_ready) hs_cyc = cyc;
            if (m_axi_arvalid && m_axi_arready) begin n_ar++; ar_hs_cyc = cyc; end
            if (m_axi_rvalid && m_axi_rready) n_r++;
            if (m_axi_bvalid && m_axi_bready) n_b++;
            if (m_axi_awvalid) begin
                awv_cycles++;
                if (aw_hold && m_axi_awaddr !== aw_hold_addr) aw_unstable = 1'b1;
                if (m_axi_awready) aw_hs_addr = m_axi_awaddr;
                aw_hold      = !m_axi_awready;
                aw_hold_addr = m_axi_awaddr;
            end else begin
                aw_hold = 1'b0;
            end
            if (m_axi_wvalid) begin
                wv_cycles++;
                if (m_axi_wready) begin w_hs_data = m_axi_wdata; w_hs_strb = m_axi_wstrb; end
            end
            if (rsp_valid && !rsp_prev) rsp_first_cyc = cyc;
            rsp_prev = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                obs[obs_wr % 64] = {rsp_rdata, rsp_err};
                obs_wr++;
                rsp_hs_cyc = cyc;
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic keep, input rsp_t exp);
        logic ok;
        req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        sb.push_back(exp);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        #1;
        if (!keep) req_valid = 1'b0;
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $display("FAIL req_accept: addr=%h never accepted within 50 cycles", a);
        end
    endtask

    task automatic wait_rsp();
        rsp_t exp;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int i = 0; i < 100 && obs_wr == obs_rd; i++) @(posedge clk);
            n_checks++;
            if (obs_wr == obs_rd) begin
                n_errors++;
                $display("FAIL rsp_arrive: no response within 100 cycles, expected rdata=%h err=%b",
                         exp.rdata, exp.err);
            end else begin
                if (obs[obs_rd % 64] !== exp) begin
                    n_errors++;
                    $display("FAIL rsp_value: got rdata=%h err=%b, expected rdata=%h err=%b",
                             obs[obs_rd % 64].rdata, obs[obs_rd % 64].err, exp.rdata, exp.err);
                end
                obs_rd++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctl_vec();
        return {req_ready, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid,
                m_axi_rready, m_axi_bready, rsp_valid, rsp_err};
    endfunction

    task automatic test_reset();
        logic [7:0] exp_ctl;
        exp_ctl = {1'b1, 1'b0, 1'b0, 1'b0, TB_DRAIN, TB_DRAIN, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ctl_vec() !== exp_ctl) begin
            n_errors++;
            $display("FAIL reset_ctl: got %b, expected %b", ctl_vec(), exp_ctl);
        end
        n_checks++;
        if ({rsp_rdata, m_axi_araddr, m_axi_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: rdata=%h araddr=%h wdata=%h, expected all zero",
                     rsp_rdata, m_axi_araddr, m_axi_wdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl_vec() !== exp_ctl) begin
            n_errors++;
            $display("FAIL reset_release: got %b, expected %b", ctl_vec(), exp_ctl);
        end
    endtask

    task automatic test_read_zero_wait();
        int ar0;
        ar0 = n_ar;
        rd_from_addr = 1'b0; slv_rdata = 32'h5; slv_rresp = RESP_OKAY; ar_wait = 0;
        issue(1'b0, 28'hC200004, '0, '0, 1'b0, '{rdata: 32'h5, err: 1'b0});
        wait_rsp();
        n_checks++;
        if (rsp_first_cyc - hs_cyc !== 3) begin
            n_errors++;
            $display("FAIL read_latency: got %0d cycles, expected 3", rsp_first_cyc - hs_cyc);
        end
        n_checks++;
        if (n_ar - ar0 !== 1) begin
            n_errors++;
            $display("FAIL read_ar_count: got %0d AR beats, expected 1", n_ar - ar0);
        end
    endtask

    task automatic test_write_aw_delay();
        int awv0, wv0, b0;
        awv0 = awv_cycles; wv0 = wv_cycles; b0 = n_b;
        aw_unstable = 1'b0;
        aw_wait = 2; w_wait = 0; slv_bresp = RESP_OKAY;
        issue(1'b1, 28'h0000004, 32'h7, 4'hF, 1'b0, '{rdata: 32'h0, err: 1'b0});
        wait_rsp();
        n_checks++;
        if (wv_cycles - wv0 !== 1 || awv_cycles - awv0 !== 3) begin
            n_errors++;
            $display("FAIL write_valid_cycles: wvalid=%0d awvalid=%0d, expected 1 and 3",
                     wv_cycles - wv0, awv_cycles - awv0);
        end
        n_checks++;
        if (aw_unstable !== 1'b0) begin
            n_errors++;
            $display("FAIL write_aw_stable: awaddr changed while awvalid waited for awready");
        end
        n_checks++;
        if ({aw_hs_addr, w_hs_data, w_hs_strb} !== {28'h0000004, 32'h7, 4'hF}) begin
            n_errors++;
            $display("FAIL write_payload: addr=%h data=%h strb=%h, expected 0000004/00000007/f",
                     aw_hs_addr, w_hs_data, w_hs_strb);
        end
        n_checks++;
        if (n_b - b0 !== 1 || rsp_first_cyc - hs_cyc !== 5) begin
            n_errors++;
            $display("FAIL write_b: B beats=%0d latency=%0d, expected 1 and 5",
                     n_b - b0, rsp_first_cyc - hs_cyc);
        end
        // Same-cycle AW/W completion with an error response.
        aw_wait = 0; slv_bresp = RESP_SLVERR;
        issue(1'b1, 28'h0000008, 32'h1234_5678, 4'h3, 1'b0, '{rdata: 32'h0, err: 1'b1});
        wait_rsp();
        n_checks++;
        if (rsp_first_cyc - hs_cyc !== 3) begin
            n_errors++;
            $display("FAIL write_latency: got %0d cycles, expected 3", rsp_first_cyc - hs_cyc);
        end
        slv_bresp = RESP_OKAY;
    endtask

    task automatic test_read_err_hold();
        logic seen;
        rsp_ready = 1'b0;
        slv_rdata = 32'h0000_ABCD; slv_rresp = RESP_DECERR;
        issue(1'b0, 28'h0000040, '0, '0, 1'b0, '{rdata: 32'h0000_ABCD, err: 1'b1});
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_rsp_arrive: rsp_valid=%b, expected 1 within 30 cycles", rsp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0000_ABCD}) begin
                n_errors++;
                $display("FAIL hold_stable[%0d]: valid=%b req_ready=%b err=%b rdata=%h, expected 1/0/1/0000abcd",
                         i, rsp_valid, req_ready, rsp_err, rsp_rdata);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_rsp();
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL hold_release: req_ready=%b rsp_valid=%b, expected 1 and 0", req_ready, rsp_valid);
        end
        slv_rresp = RESP_OKAY;
    endtask

    task automatic test_back_to_back();
        int ar0, hs2;
        ar0 = n_ar;
        rd_from_addr = 1'b1; ar_wait = 1;
        issue(1'b0, 28'h0000100, '0, '0, 1'b1, '{rdata: 32'hA000_0100, err: 1'b0});
        issue(1'b0, 28'h0000200, '0, '0, 1'b0, '{rdata: 32'hA000_0200, err: 1'b0});
        hs2 = hs_cyc;
        n_checks++;
        if (hs2 !== rsp_hs_cyc + 1) begin
            n_errors++;
            $display("FAIL b2b_accept: second accepted at cycle %0d, expected %0d",
                     hs2, rsp_hs_cyc + 1);
        end
        wait_rsp();
        n_checks++;
        if (n_ar - ar0 !== 2) begin
            n_errors++;
            $display("FAIL b2b_ar_count: got %0d AR beats, expected 2", n_ar - ar0);
        end
        ar_wait = 0;
    endtask

    task automatic test_reset_in_wresp();
        logic seen;
        b_enable = 1'b0;
        issue(1'b1, 28'h0000300, 32'hCAFE_F00D, 4'hF, 1'b0, '{rdata: 32'h0, err: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_axi_bready) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++;
            $display("FAIL wresp_reach: bready=%b, expected 1 within 20 cycles", m_axi_bready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, rsp_valid, req_ready} !== 5'b00001) begin
            n_errors++;
            $display("FAIL reset_abort: ar/aw/w/rsp valid,req_ready=%b, expected 00001",
                     {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, rsp_valid, req_ready});
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        b_enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req_ready, m_axi_bready, m_axi_bvalid} !== {1'b1, TB_DRAIN, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_recover: req_ready=%b bready=%b bvalid=%b, expected 1/%b/0",
                     req_ready, m_axi_bready, m_axi_bvalid, TB_DRAIN);
        end
        issue(1'b0, 28'h0000020, '0, '0, 1'b0, '{rdata: 32'hA000_0020, err: 1'b0});
        wait_rsp();
    endtask

`ifdef AXIL_TIMEOUT_EN
    task automatic test_timeout();
        int rsp0, r0;
        r_enable = 1'b0;
        issue(1'b0, 28'h0000010, '0, '0, 1'b0, '{rdata: 32'hDEAD_BEEF, err: 1'b1});
        wait_rsp();
        n_checks++;
        if (rsp_first_cyc - ar_hs_cyc !== TIMEOUT) begin
            n_errors++;
            $display("FAIL timeout_latency: got %0d cycles after AR, expected %0d",
                     rsp_first_cyc - ar_hs_cyc, TIMEOUT);
        end
        rsp0 = obs_wr; r0 = n_r;
        r_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if ({obs_wr - rsp0, n_r - r0} !== {32'd0, 32'd1}) begin
            n_errors++;
            $display("FAIL timeout_stale: extra responses=%0d R beats=%0d, expected 0 and 1",
                     obs_wr - rsp0, n_r - r0);
        end
        issue(1'b0, 28'h0000030, '0, '0, 1'b0, '{rdata: 32'hA000_0030, err: 1'b0});
        wait_rsp();
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_aw_delay();
        test_read_err_hold();
        test_back_to_back();
        test_reset_in_wresp();
`ifdef AXIL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
